div_arbiter: RTL and testbench

//  Shares one iterative divider between the two EX pipelines of the dual-issue core.

---
 rtl/div_arbiter_pkg.sv | 19 +
 rtl/div_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_div_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared encodings for the divider arbiter: FSM states, line owner and the
// default operand width used by the EX stage.
package div_arbiter_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  typedef enum logic {
    OWN_L1 = 1'b0,
    OWN_L2 = 1'b1
  } div_owner_t;

endpackage

// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider between the two EX pipelines.
// Fixed priority line1 > line2, start/done handshake sequencing, flush squash.
// Optional feature macro: DIV_RESULT_REUSE_EN (reuse the last completed result
// when an identical request arrives, skipping the divider).
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             excep_flush_i,
  input  logic             line1_req_i,
  input  logic             line1_sign_i,
  input  logic [WIDTH-1:0] line1_dividend_i,
  input  logic [WIDTH-1:0] line1_divisor_i,
  output logic             line1_done_o,
  output logic [WIDTH-1:0] line1_quotient_o,
  output logic [WIDTH-1:0] line1_remainder_o,
  input  logic             line2_req_i,
  input  logic             line2_sign_i,
  input  logic [WIDTH-1:0] line2_dividend_i,
  input  logic [WIDTH-1:0] line2_divisor_i,
  output logic             line2_done_o,
  output logic [WIDTH-1:0] line2_quotient_o,
  output logic [WIDTH-1:0] line2_remainder_o,
  output logic             div_start_o,
  output logic             div_sign_o,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  input  logic             div_done_i,
  input  logic [WIDTH-1:0] div_quotient_i,
  input  logic [WIDTH-1:0] div_remainder_i
);

  div_state_t       state_r, state_s;
  div_owner_t       owner_r, sel_owner_s, load_owner_s;
  logic             sel_sign_s;
  logic [WIDTH-1:0] sel_dividend_s, sel_divisor_s;
  logic             any_req_s, owner_req_s, hit_s;
  logic             latch_s, start_s, load_s;
  logic [WIDTH-1:0] load_q_s, load_r_s;
  logic             div_start_r, div_sign_r;
  logic [WIDTH-1:0] div_dividend_r, div_divisor_r;
  logic [WIDTH-1:0] l1_q_r, l1_rem_r, l2_q_r, l2_rem_r;

  assign any_req_s = line1_req_i | line2_req_i;

  // Fixed-priority pick: line1 holds the older instruction of the bundle.
  always_comb begin
    sel_owner_s    = OWN_L1;
    sel_sign_s     = line1_sign_i;
    sel_dividend_s = line1_dividend_i;
    sel_divisor_s  = line1_divisor_i;
    if (line1_req_i) begin
      sel_owner_s    = OWN_L1;
      sel_sign_s     = line1_sign_i;
      sel_dividend_s = line1_dividend_i;
      sel_divisor_s  = line1_divisor_i;
    end else begin
      sel_owner_s    = OWN_L2;
      sel_sign_s     = line2_sign_i;
      sel_dividend_s = line2_dividend_i;
      sel_divisor_s  = line2_divisor_i;
    end
  end

  // Request level of the line that currently owns the divider.
  always_comb begin
    owner_req_s = 1'b0;
    if (owner_r == OWN_L1) begin
      owner_req_s = line1_req_i;
    end else begin
      owner_req_s = line2_req_i;
    end
  end

`ifdef DIV_RESULT_REUSE_EN
  logic             cache_valid_r, cache_sign_r;
  logic [WIDTH-1:0] cache_dividend_r, cache_divisor_r, cache_q_r, cache_rem_r;
  logic             store_s;

  // Only results that reach DONE from a real divider pass are remembered.
  assign store_s = load_s && (state_r == BUSY);

  // Last completed division; valid is cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_r    <= 1'b0;
      cache_sign_r     <= 1'b0;
      cache_dividend_r <= '0;
      cache_divisor_r  <= '0;
      cache_q_r        <= '0;
      cache_rem_r      <= '0;
    end else if (store_s) begin
      cache_valid_r    <= 1'b1;
      cache_sign_r     <= div_sign_r;
      cache_dividend_r <= div_dividend_r;
      cache_divisor_r  <= div_divisor_r;
      cache_q_r        <= div_quotient_i;
      cache_rem_r      <= div_remainder_i;
    end
  end

  assign hit_s = cache_valid_r && (cache_sign_r == sel_sign_s) &&
                 (cache_dividend_r == sel_dividend_s) && (cache_divisor_r == sel_divisor_s);

  // Result source: the cache on an IDLE reuse hit, the divider otherwise.
  always_comb begin
    load_q_s = div_quotient_i;
    load_r_s = div_remainder_i;
    if (state_r == IDLE) begin
      load_q_s = cache_q_r;
      load_r_s = cache_rem_r;
    end else begin
      load_q_s = div_quotient_i;
      load_r_s = div_remainder_i;
    end
  end
`else
  assign hit_s    = 1'b0;
  assign load_q_s = div_quotient_i;
  assign load_r_s = div_remainder_i;
`endif

  // Next-state logic and the per-cycle control strobes.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    start_s = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s && !excep_flush_i) begin
          latch_s = 1'b1;
          if (hit_s) begin
            load_s  = 1'b1;
            state_s = DONE;
          end else begin
            start_s = 1'b1;
            state_s = BUSY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (div_done_i) begin
          // A squashed or abandoned result is simply dropped.
          if (excep_flush_i || !owner_req_s) begin
            state_s = IDLE;
          end else begin
            load_s  = 1'b1;
            state_s = DONE;
          end
        end else if (excep_flush_i || !owner_req_s) begin
          state_s = DRAIN;
        end else begin
          state_s = BUSY;
        end
      end
      DRAIN: begin
        // The divider cannot abort: wait for it, then discard its result.
        if (div_done_i) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // A reuse hit is loaded in IDLE, before owner_r has been updated.
  always_comb begin
    load_owner_s = owner_r;
    if (state_r == IDLE) begin
      load_owner_s = sel_owner_s;
    end else begin
      load_owner_s = owner_r;
    end
  end

  // State and owner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      owner_r <= OWN_L1;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        owner_r <= sel_owner_s;
      end
    end
  end

  // Divider side: one-cycle start pulse, operands held for the whole pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_start_r    <= 1'b0;
      div_sign_r     <= 1'b0;
      div_dividend_r <= '0;
      div_divisor_r  <= '0;
    end else begin
      div_start_r <= start_s;
      if (latch_s) begin
        div_sign_r     <= sel_sign_s;
        div_dividend_r <= sel_dividend_s;
        div_divisor_r  <= sel_divisor_s;
      end
    end
  end

  // Per-line result registers; the line that did not own the result reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      l1_q_r   <= '0;
      l1_rem_r <= '0;
      l2_q_r   <= '0;
      l2_rem_r <= '0;
    end else if (load_s) begin
      if (load_owner_s == OWN_L1) begin
        l1_q_r   <= load_q_s;
        l1_rem_r <= load_r_s;
        l2_q_r   <= '0;
        l2_rem_r <= '0;
      end else begin
        l1_q_r   <= '0;
        l1_rem_r <= '0;
        l2_q_r   <= load_q_s;
        l2_rem_r <= load_r_s;
      end
    end
  end

  // The done pulse is the DONE cycle itself; a flush in that cycle kills it.
  assign line1_done_o      = (state_r == DONE) && (owner_r == OWN_L1) && !excep_flush_i;
  assign line2_done_o      = (state_r == DONE) && (owner_r == OWN_L2) && !excep_flush_i;
  assign line1_quotient_o  = l1_q_r;
  assign line1_remainder_o = l1_rem_r;
  assign line2_quotient_o  = l2_q_r;
  assign line2_remainder_o = l2_rem_r;
  assign div_start_o       = div_start_r;
  assign div_sign_o        = div_sign_r;
  assign div_dividend_o    = div_dividend_r;
  assign div_divisor_o     = div_divisor_r;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: directed requests push expected
// {line, quotient, remainder, cycle}; a monitor pops on every done pulse.
// A small divider responder returns hand-computed results after a set latency.
`timescale 1ns/1ps
module tb_div_arbiter;

  localparam int W = 32;

  logic         clk, reset, excep_flush_i;
  logic         line1_req_i, line1_sign_i, line1_done_o;
  logic [W-1:0] line1_dividend_i, line1_divisor_i, line1_quotient_o, line1_remainder_o;
  logic         line2_req_i, line2_sign_i, line2_done_o;
  logic [W-1:0] line2_dividend_i, line2_divisor_i, line2_quotient_o, line2_remainder_o;
  logic         div_start_o, div_sign_o, div_done_i;
  logic [W-1:0] div_dividend_o, div_divisor_o, div_quotient_i, div_remainder_i;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  typedef struct {int line; logic [W-1:0] q; logic [W-1:0] r; int cyc;} exp_t;
  typedef struct {int lat; logic [W-1:0] q; logic [W-1:0] r;} resp_t;
  exp_t  exp_q[$];
  resp_t resp_q[$];

  div_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .excep_flush_i(excep_flush_i),
    .line1_req_i(line1_req_i), .line1_sign_i(line1_sign_i),
    .line1_dividend_i(line1_dividend_i), .line1_divisor_i(line1_divisor_i),
    .line1_done_o(line1_done_o), .line1_quotient_o(line1_quotient_o),
    .line1_remainder_o(line1_remainder_o),
    .line2_req_i(line2_req_i), .line2_sign_i(line2_sign_i),
    .line2_dividend_i(line2_dividend_i), .line2_divisor_i(line2_divisor_i),
    .line2_done_o(line2_done_o), .line2_quotient_o(line2_quotient_o),
    .line2_remainder_o(line2_remainder_o),
    .div_start_o(div_start_o), .div_sign_o(div_sign_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_done_i(div_done_i), .div_quotient_i(div_quotient_i),
    .div_remainder_i(div_remainder_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) cycle();
  endtask

  function automatic exp_t mk_exp(input int line, input logic [W-1:0] q, input logic [W-1:0] r, input int c);
    exp_t e;
    e.line = line; e.q = q; e.r = r; e.cyc = c;
    return e;
  endfunction

  function automatic resp_t mk_resp(input int lat, input logic [W-1:0] q, input logic [W-1:0] r);
    resp_t p;
    p.lat = lat; p.q = q; p.r = r;
    return p;
  endfunction

  task automatic set_line(input int line, input logic req, input logic sgn,
                          input logic [W-1:0] dd, input logic [W-1:0] dv);
    if (line == 1) begin
      line1_req_i = req; line1_sign_i = sgn; line1_dividend_i = dd; line1_divisor_i = dv;
    end else begin
      line2_req_i = req; line2_sign_i = sgn; line2_dividend_i = dd; line2_divisor_i = dv;
    end
  endtask

  // Single request through the divider: start at T+1, done at T+lat+2.
  task automatic run_one(input int line, input logic sgn, input logic [W-1:0] dd,
                         input logic [W-1:0] dv, input logic [W-1:0] q,
                         input logic [W-1:0] r, input int lat);
    int t;
    resp_q.push_back(mk_resp(lat, q, r));
    set_line(line, 1'b1, sgn, dd, dv);
    t = cyc;
    exp_q.push_back(mk_exp(line, q, r, t + lat + 2));
    @(negedge clk);
    chk("start_not_early", 32'(div_start_o), 32'd0);
    cycle();
    @(negedge clk);
    chk("start_pulse", 32'(div_start_o), 32'd1);
    chk("div_sign", 32'(div_sign_o), 32'(sgn));
    chk("div_dividend", div_dividend_o, dd);
    chk("div_divisor", div_divisor_o, dv);
    wait_cyc(t + lat + 2);
    set_line(line, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle();
    cycle();
  endtask

  // Divider responder: on each start pulse return the next queued result.
  initial begin
    resp_t p;
    div_done_i = 1'b0; div_quotient_i = 32'd0; div_remainder_i = 32'd0;
    forever begin
      @(negedge clk);
      if (div_start_o) begin
        start_cnt++;
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start at cycle %0d: actual start=1, required none", cyc);
        end else begin
          p = resp_q.pop_front();
          repeat (p.lat) @(posedge clk);
          #1;
          div_done_i = 1'b1; div_quotient_i = p.q; div_remainder_i = p.r;
          @(posedge clk);
          #1;
          div_done_i = 1'b0; div_quotient_i = 32'd0; div_remainder_i = 32'd0;
        end
      end
    end
  end

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (line1_done_o || line2_done_o)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at cycle %0d: actual line1=%0b line2=%0b, required no pulse",
                   cyc, line1_done_o, line2_done_o);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_line", {30'd0, line2_done_o, line1_done_o}, (e.line == 1) ? 32'd1 : 32'd2);
          if (e.line == 1) begin
            chk("l1_quotient", line1_quotient_o, e.q);
            chk("l1_remainder", line1_remainder_o, e.r);
            chk("l2_nonowner_zero", line2_quotient_o | line2_remainder_o, 32'd0);
          end else begin
            chk("l2_quotient", line2_quotient_o, e.q);
            chk("l2_remainder", line2_remainder_o, e.r);
            chk("l1_nonowner_zero", line1_quotient_o | line1_remainder_o, 32'd0);
          end
        end
      end
    end
  end

  initial begin
    int t, s, s0;
    reset = 1'b1; excep_flush_i = 1'b0;
    set_line(1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_line(2, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) cycle();
    @(negedge clk);
    chk("reset_ctrl", {28'd0, div_start_o, div_sign_o, line1_done_o, line2_done_o}, 32'd0);
    chk("reset_operands", div_dividend_o | div_divisor_o, 32'd0);
    chk("reset_results", line1_quotient_o | line1_remainder_o | line2_quotient_o | line2_remainder_o, 32'd0);
    cycle();
    reset = 1'b0;
    cycle();

    // 1: line1 7/2 unsigned, divider latency 8
    run_one(1, 1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 8);

    // 2: both lines request together; line1 first, line2 right after IDLE
    resp_q.push_back(mk_resp(4, 32'd14, 32'd2));
    resp_q.push_back(mk_resp(4, 32'd3, 32'd0));
    set_line(1, 1'b1, 1'b0, 32'd100, 32'd7);
    set_line(2, 1'b1, 1'b0, 32'd9, 32'd3);
    t = cyc;
    exp_q.push_back(mk_exp(1, 32'd14, 32'd2, t + 6));
    exp_q.push_back(mk_exp(2, 32'd3, 32'd0, t + 13));
    cycle();
    @(negedge clk);
    chk("prio_start", 32'(div_start_o), 32'd1);
    chk("prio_dividend", div_dividend_o, 32'd100);
    wait_cyc(t + 6);
    set_line(1, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_cyc(t + 7);
    @(negedge clk);
    chk("l2_wait_idle", 32'(div_start_o), 32'd0);
    cycle();
    @(negedge clk);
    chk("l2_start", 32'(div_start_o), 32'd1);
    chk("l2_dividend", div_dividend_o, 32'd9);
    wait_cyc(t + 13);
    set_line(2, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(); cycle();

    // 3: flush 3 cycles after start -> DRAIN; line2 waits for IDLE
    resp_q.push_back(mk_resp(8, 32'hDEAD, 32'hBEEF));
    resp_q.push_back(mk_resp(3, 32'd5, 32'd0));
    set_line(1, 1'b1, 1'b0, 32'd50, 32'd5);
    s = cyc + 1;
    wait_cyc(s + 3);
    excep_flush_i = 1'b1;
    wait_cyc(s + 4);
    excep_flush_i = 1'b0;
    set_line(1, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_cyc(s + 5);
    set_line(2, 1'b1, 1'b0, 32'd10, 32'd2);
    exp_q.push_back(mk_exp(2, 32'd5, 32'd0, s + 14));
    while (cyc < s + 10) begin
      @(negedge clk);
      chk("drain_no_start", 32'(div_start_o), 32'd0);
      cycle();
    end
    @(negedge clk);
    chk("post_drain_start", 32'(div_start_o), 32'd1);
    wait_cyc(s + 14);
    set_line(2, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(); cycle();

    // 4: flush together with div_done -> no pulse, IDLE on the next cycle
    resp_q.push_back(mk_resp(5, 32'd11, 32'd0));
    resp_q.push_back(mk_resp(2, 32'd3, 32'd2));
    set_line(1, 1'b1, 1'b0, 32'd77, 32'd7);
    s = cyc + 1;
    wait_cyc(s + 5);
    excep_flush_i = 1'b1;
    wait_cyc(s + 6);
    excep_flush_i = 1'b0;
    set_line(1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_line(2, 1'b1, 1'b0, 32'd20, 32'd6);
    exp_q.push_back(mk_exp(2, 32'd3, 32'd2, s + 10));
    cycle();
    @(negedge clk);
    chk("flush_done_idle_start", 32'(div_start_o), 32'd1);
    wait_cyc(s + 10);
    set_line(2, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(); cycle();

    // 5: signed -7/2, operands and result passed bit-exact
    run_one(1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 6);

    // 6: 13/4 twice; the repeat reuses the result when the feature is built in
    run_one(1, 1'b0, 32'd13, 32'd4, 32'd3, 32'd1, 5);
    s0 = start_cnt;
    set_line(1, 1'b1, 1'b0, 32'd13, 32'd4);
    t = cyc;
`ifdef DIV_RESULT_REUSE_EN
    exp_q.push_back(mk_exp(1, 32'd3, 32'd1, t + 1));
    wait_cyc(t + 1);
    set_line(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("reuse_no_start", 32'(div_start_o), 32'd0);
    cycle(); cycle(); cycle();
    chk("reuse_start_count", 32'(start_cnt - s0), 32'd0);
`else
    resp_q.push_back(mk_resp(3, 32'd3, 32'd1));
    exp_q.push_back(mk_exp(1, 32'd3, 32'd1, t + 5));
    wait_cyc(t + 5);
    set_line(1, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(); cycle();
    chk("full_pass_start_count", 32'(start_cnt - s0), 32'd1);
`endif

    // 7: flush during the DONE cycle suppresses the pulse
    resp_q.push_back(mk_resp(2, 32'd7, 32'd2));
    set_line(2, 1'b1, 1'b0, 32'd30, 32'd4);
    t = cyc;
    wait_cyc(t + 4);
    excep_flush_i = 1'b1;
    set_line(2, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("done_flush_suppressed", {30'd0, line2_done_o, line1_done_o}, 32'd0);
    cycle();
    excep_flush_i = 1'b0;
    cycle(); cycle();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
    chk("pending_done", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
